// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
//   NUM_CH independent programmable clock dividers, all running from one
//   reference clock. Each channel is an IDLE/BYPASS/DIVIDE state machine with
//   a period counter and a shadow copy of its ratio. The shadow is only
//   reloaded at the end of a period, so a ratio change never truncates or
//   stretches the period in flight.
//
//   Ratio 0 or 1 selects BYPASS: the output is the reference clock itself and
//   the tick is held high. Ratio N >= 2 divides by N, high for floor(N/2)
//   cycles.
//
//   Optional feature (macro CLK_DIV_DUTY50_EN): for odd N a falling-edge
//   register stretches the high phase by half a reference cycle, giving an
//   exact 50% duty cycle. Without the macro no falling-edge logic exists.
//
// Ports
//   i_ref_clk    in   1                    reference clock (rising edge)
//   i_rst        in   1                    asynchronous active-high reset
//   i_clk_en     in   NUM_CH               per-channel enable
//   i_div_ratio  in   NUM_CH*RATIO_WIDTH   per-channel ratio, channel c at
//                                          [c*RATIO_WIDTH +: RATIO_WIDTH]
//   o_div_clk    out  NUM_CH               divided clock
//   o_tick       out  NUM_CH               pulse on each divided rising edge
//   o_ratio_ack  out  NUM_CH               pulse when a new ratio is adopted
// -----------------------------------------------------------------------------
module clk_div_multi #(
  parameter int NUM_CH      = 4,
  parameter int RATIO_WIDTH = 8
) (
  input  logic                          i_ref_clk,
  input  logic                          i_rst,
  input  logic [NUM_CH-1:0]             i_clk_en,
  input  logic [NUM_CH*RATIO_WIDTH-1:0] i_div_ratio,
  output logic [NUM_CH-1:0]             o_div_clk,
  output logic [NUM_CH-1:0]             o_tick,
  output logic [NUM_CH-1:0]             o_ratio_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYPASS = 2'd1,
    DIVIDE = 2'd2
  } state_t;

  localparam logic [RATIO_WIDTH-1:0] ZERO = RATIO_WIDTH'(0);
  localparam logic [RATIO_WIDTH-1:0] ONE  = RATIO_WIDTH'(1);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t                 state_r;
    logic [RATIO_WIDTH-1:0] count_r;
    logic [RATIO_WIDTH-1:0] shadow_r;
    logic                   div_r;
    logic                   tick_r;
    logic                   ack_r;

    logic [RATIO_WIDTH-1:0] ratio_s;
    logic [RATIO_WIDTH-1:0] count_inc_s;
    logic [RATIO_WIDTH-1:0] half_s;
    logic                   ratio_div_s;
    logic                   wrap_s;
    logic                   stretch_s;

    assign ratio_s     = i_div_ratio[c*RATIO_WIDTH +: RATIO_WIDTH];
    assign ratio_div_s = (ratio_s > ONE);
    assign half_s      = shadow_r >> 1;
    // In DIVIDE the counter stays below shadow-1, so this increment never
    // overflows even for the all-ones ratio.
    assign count_inc_s = count_r + ONE;
    assign wrap_s      = (count_r == (shadow_r - ONE));

    // Channel state machine, counter, shadow ratio and registered outputs.
    always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) begin
        state_r  <= IDLE;
        count_r  <= ZERO;
        shadow_r <= ZERO;
        div_r    <= 1'b0;
        tick_r   <= 1'b0;
        ack_r    <= 1'b0;
      end else begin
        ack_r <= 1'b0;
        case (state_r)
          IDLE: begin
            count_r <= ZERO;
            if (i_clk_en[c]) begin
              shadow_r <= ratio_s;
              tick_r   <= 1'b1;
              if (ratio_div_s) begin
                div_r   <= 1'b1;
                state_r <= DIVIDE;
              end else begin
                div_r   <= 1'b0;
                state_r <= BYPASS;
              end
            end else begin
              div_r  <= 1'b0;
              tick_r <= 1'b0;
            end
          end
          DIVIDE: begin
            if (!i_clk_en[c]) begin
              state_r <= IDLE;
              count_r <= ZERO;
              div_r   <= 1'b0;
              tick_r  <= 1'b0;
            end else if (wrap_s) begin
              // End of period: the only point a new ratio is taken.
              count_r  <= ZERO;
              shadow_r <= ratio_s;
              ack_r    <= (ratio_s != shadow_r);
              tick_r   <= 1'b1;
              if (ratio_div_s) begin
                div_r <= 1'b1;
              end else begin
                div_r   <= 1'b0;
                state_r <= BYPASS;
              end
            end else begin
              count_r <= count_inc_s;
              div_r   <= (count_inc_s < half_s);
              tick_r  <= 1'b0;
            end
          end
          BYPASS: begin
            count_r <= ZERO;
            if (!i_clk_en[c]) begin
              state_r <= IDLE;
              div_r   <= 1'b0;
              tick_r  <= 1'b0;
            end else if (ratio_div_s) begin
              shadow_r <= ratio_s;
              div_r    <= 1'b1;
              tick_r   <= 1'b1;
              ack_r    <= 1'b1;
              state_r  <= DIVIDE;
            end else begin
              // Switching between ratio 0 and 1 stays in BYPASS.
              shadow_r <= ratio_s;
              ack_r    <= (ratio_s != shadow_r);
              div_r    <= 1'b0;
              tick_r   <= 1'b1;
            end
          end
          default: begin
            state_r <= IDLE;
            count_r <= ZERO;
            div_r   <= 1'b0;
            tick_r  <= 1'b0;
          end
        endcase
      end
    end

`ifdef CLK_DIV_DUTY50_EN
    logic ext_r;

    // Half-cycle delayed copy of the divided clock, used to stretch odd ratios.
    always_ff @(negedge i_ref_clk or posedge i_rst) begin
      if (i_rst) begin
        ext_r <= 1'b0;
      end else begin
        ext_r <= div_r;
      end
    end

    // In DIVIDE the shadow is >= 2, so an odd shadow means N >= 3.
    assign stretch_s = ext_r & shadow_r[0] & (state_r == DIVIDE);
`else
    assign stretch_s = 1'b0;
`endif

    assign o_div_clk[c]   = (state_r == BYPASS) ? i_ref_clk : (div_r | stretch_s);
    assign o_tick[c]      = tick_r;
    assign o_ratio_ack[c] = ack_r;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_div_multi
//   Directed bench for clk_div_multi (4 channels, 8-bit ratios, 10 ns clock).
//   Outputs are sampled 1 ns after the rising edge (and 1 ns after the falling
//   edge where BYPASS or duty stretching matters) and compared with
//   hand-derived per-cycle patterns.
// -----------------------------------------------------------------------------
module tb_clk_div_multi;

  localparam int NCH = 4;
  localparam int RW  = 8;

`ifdef CLK_DIV_DUTY50_EN
  localparam bit DUTY50 = 1'b1;
`else
  localparam bit DUTY50 = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NCH-1:0]    en = '0;
  logic [NCH*RW-1:0] ratio = '0;
  logic [NCH-1:0]    div_clk;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    ack;

  int checks = 0;
  int errors = 0;

  clk_div_multi #(.NUM_CH(NCH), .RATIO_WIDTH(RW)) dut (
    .i_ref_clk   (clk),
    .i_rst       (rst),
    .i_clk_en    (en),
    .i_div_ratio (ratio),
    .o_div_clk   (div_clk),
    .o_tick      (tick),
    .o_ratio_ack (ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle patterns for phase A, bit k = cycle k after enabling.
  logic [11:0] d0, d1, d2, d3, t0, t1, t2, t3, a2, a3;
  logic [NCH-1:0] exp_div, exp_tick, exp_ack;

  initial begin
    d0 = 12'b0011_0011_0011;
    t0 = 12'b0001_0001_0001;
    d1 = DUTY50 ? 12'b1100_1110_0111 : 12'b1100_0110_0011;
    t1 = 12'b0100_0010_0001;
    d2 = DUTY50 ? 12'b0110_1100_0111 : 12'b0010_0100_0111;
    t2 = 12'b0010_0100_0001;
    a2 = 12'b0000_0100_0000;
    d3 = 12'b1111_1111_0011;
    t3 = 12'b1111_1111_0001;
    a3 = 12'b0000_0001_0000;

    // Reset state, asserted between edges.
    #1 rst = 1'b1;
    #2;
    check("rst div", 32'(div_clk), 32'h0);
    check("rst tick", 32'(tick), 32'h0);
    check("rst ack", 32'(ack), 32'h0);
    step();
    step();
    check("rst hold div", 32'(div_clk), 32'h0);
    rst = 1'b0;

    // Phase A: ch0=4, ch1=5, ch2=6 then 3, ch3=4 then 1 (bypass).
    ratio[0*RW +: RW] = 8'd4;
    ratio[1*RW +: RW] = 8'd5;
    ratio[2*RW +: RW] = 8'd6;
    ratio[3*RW +: RW] = 8'd4;
    en = 4'b1111;
    step();
    for (int k = 0; k < 12; k++) begin
      exp_div  = {d3[k], d2[k], d1[k], d0[k]};
      exp_tick = {t3[k], t2[k], t1[k], t0[k]};
      exp_ack  = {a3[k], a2[k], 1'b0, 1'b0};
      check($sformatf("A div k%0d", k), 32'(div_clk), 32'(exp_div));
      check($sformatf("A tick k%0d", k), 32'(tick), 32'(exp_tick));
      check($sformatf("A ack k%0d", k), 32'(ack), 32'(exp_ack));
      if (k == 1) begin
        ratio[2*RW +: RW] = 8'd3;
        ratio[3*RW +: RW] = 8'd1;
      end
      if (k < 11) step();
    end
    // BYPASS output follows the reference clock low phase.
    @(negedge clk);
    #1;
    check("bypass low", 32'(div_clk[3]), 32'h0);

    // Phase B: drop ch0 enable at counter 1; others continue.
    step();                 // k12, ch0 counter 0
    step();                 // k13, ch0 counter 1
    en = 4'b1110;
    step();                 // k14
    check("B div k14", 32'(div_clk), 32'h8);
    check("B tick k14", 32'(tick), 32'h8);
    step();                 // k15
    check("B div k15", 32'(div_clk), 32'he);
    check("B tick k15", 32'(tick), 32'he);
    check("B ack k15", 32'(ack), 32'h0);
    step();                 // k16
    check("B div k16", 32'(div_clk), DUTY50 ? 32'he : 32'ha);
    check("B tick k16", 32'(tick), 32'h8);

    // Phase C: ch3 leaves BYPASS for ratio 2.
    ratio[3*RW +: RW] = 8'd2;
    step();                 // k17
    check("C div3 k17", 32'(div_clk[3]), 32'h1);
    check("C tick3 k17", 32'(tick[3]), 32'h1);
    check("C ack k17", 32'(ack), 32'h8);
    step();                 // k18
    check("C div k18", 32'(div_clk), 32'h4);
    check("C ack k18", 32'(ack), 32'h0);

    // Phase D: 3 ns reset pulse between edges while dividing.
    #1 rst = 1'b1;
    #1;
    check("D rst div", 32'(div_clk), 32'h0);
    check("D rst tick", 32'(tick), 32'h0);
    check("D rst ack", 32'(ack), 32'h0);
    #2 rst = 1'b0;
    en = 4'b1111;
    #2;
    check("D pre-edge div", 32'(div_clk), 32'h0);
    step();
    check("D first div", 32'(div_clk), 32'hf);
    check("D first tick", 32'(tick), 32'hf);
    check("D first ack", 32'(ack), 32'h0);

    // Phase E: disable all, then IDLE -> BYPASS with ratio 0.
    en = 4'b0000;
    step();
    check("E idle div", 32'(div_clk), 32'h0);
    check("E idle tick", 32'(tick), 32'h0);
    ratio[0*RW +: RW] = 8'd0;
    en = 4'b0001;
    step();
    check("E byp tick", 32'(tick), 32'h1);
    check("E byp ack", 32'(ack), 32'h0);
    check("E byp high", 32'(div_clk[0]), 32'h1);
    @(negedge clk);
    #1;
    check("E byp low", 32'(div_clk[0]), 32'h0);

    // Phase F: maximum ratio 255 on ch1.
    en = 4'b0000;
    step();
    ratio[1*RW +: RW] = 8'd255;
    en = 4'b0010;
    step();
    for (int k = 0; k < 256; k++) begin
      check($sformatf("F div k%0d", k), 32'(div_clk[1]),
            32'((k < 127) || (k == 255) || (DUTY50 && (k == 127))));
      check($sformatf("F tick k%0d", k), 32'(tick[1]), 32'((k == 0) || (k == 255)));
      if (k < 255) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
